regfile_dump_tx: RTL and testbench
==================================

// Module: regfile_dump_tx
// PURPOSE
//   Reads the CPU register file back out after each REPL instruction and streams it to the host.
//   On a start pulse, walks x0..x(NUM_REGS-1) through one register-file read port.
//   Serialises each word little-endian into bytes on a valid/ready byte stream that feeds the UART transmitter.
//   Sits between the register file read port B mux and the UART TX block.
// PARAMETERS
//   NUM_REGS  32  registers dumped per frame (x0 first)
//   ADDR_W    5   register address width; must satisfy 2**ADDR_W >= NUM_REGS
//   DATA_W    32  register width; must be a multiple of 8
// PORTS
//   clk       in   1       single clock, all logic on posedge
//   reset     in   1       synchronous, active-high reset
//   start     in   1       1-cycle request to dump; ignored while busy=1
//   busy      out  1       high from the cycle after an accepted start through the DONE cycle
//   done      out  1       1-cycle pulse after the last byte of the frame is accepted
//   rd_addr   out  ADDR_W  register file read address
//   rd_data   in   DATA_W  register file read data (combinational, includes write forwarding)
//   tx_data   out  8       byte to the transmitter
//   tx_valid  out  1       tx_data is valid
//   tx_ready  in   1       transmitter accepts the byte when tx_valid && tx_ready
// BEHAVIOUR
//   Reset values: busy=0, done=0, tx_valid=0, tx_data=0, rd_addr=0, and reg_idx, byte_idx and checksum all cleared.
//   States: IDLE -> LOAD -> SEND -> (LOAD | CKSUM | DONE) -> IDLE. Encoding comes from the package.
//   IDLE: tx_valid=0. On start, reg_idx<=0, next state LOAD.
//   LOAD: rd_addr=reg_idx; shift_reg<=rd_data; byte_idx<=0; next state SEND.
//     The captured value is whatever rd_data shows in the LOAD cycle, including the register file's same-cycle write forwarding.
//     No special-casing of x0.
//   SEND: tx_valid=1, tx_data=shift_reg[7:0].
//     On handshake: shift_reg>>=8, byte_idx++.
//     On the handshake of the last byte (byte_idx == DATA_W/8-1):
//       if reg_idx==NUM_REGS-1, go to CKSUM when enabled, else DONE;
//       otherwise reg_idx++ and go to LOAD.
//   tx_data is held stable while tx_valid=1 and tx_ready=0. tx_valid never drops without a handshake, except on reset.
//   DONE: done=1 for exactly one cycle, busy=1, tx_valid=0; next state IDLE.
//   Latency: start in cycle 0 -> LOAD in cycle 1 -> first tx_valid in cycle 2.
//   With tx_ready tied high, a frame is NUM_REGS*(1+DATA_W/8) cycles plus 1 DONE cycle (161 for the defaults), plus 1 CKSUM cycle when enabled.
//   start while busy: ignored, no queueing. start in the DONE cycle: ignored.
//   start in the cycle after DONE, i.e. in IDLE: accepted normally.
//   reset mid-frame: next cycle is IDLE with tx_valid=0. The partial frame is abandoned and no done pulse is issued.
//   rd_addr always equals reg_idx. It is not gated to LOAD, so it stays glitch-free for the read port mux.
// CONFIGURATION
//   REGFILE_DUMP_CKSUM_EN defined:
//     An 8-bit checksum is the XOR of every data byte accepted in the frame; it is cleared on accept of start.
//     After the last data byte, the CKSUM state presents the checksum with tx_valid=1 and holds it until the handshake, then goes to DONE.
//     Frame length is NUM_REGS*DATA_W/8 + 1 bytes.
//   REGFILE_DUMP_CKSUM_EN undefined: no CKSUM state and no checksum register; frame length is NUM_REGS*DATA_W/8 bytes.
// STRUCTURE
//   Shared package regfile_dump_pkg contains:
//     state encodings IDLE/LOAD/SEND/CKSUM/DONE;
//     BYTES_PER_WORD = DATA_W/8;
//     CKSUM_INIT = 8'h00.
//   Sub-module word_byte_serializer: DATA_W shift register plus byte counter.
//     Ports: load, word_in, byte_out, advance, last.
//     The FSM, reg_idx counter and checksum stay in regfile_dump_tx.
// TESTING
//   1. Preload xN = 32'h1000_0000+N and x0 = 0; pulse start with tx_ready=1.
//      Expect 128 bytes: 00 00 00 00, 01 00 00 10, ..., 1F 00 00 10.
//      Expect done in cycle 161 after start.
//   2. Apply random tx_ready backpressure at 30% duty.
//      Expect the same byte sequence, tx_data stable during every stall, and exactly one done pulse.
//   3. Pulse start again at frame byte 40 and in the DONE cycle.
//      Expect both ignored and a single 128-byte frame.
//      Then pulse start in the cycle after DONE and expect a second full frame.
//   4. Assert reset while sending byte 2 of x7.
//      Expect tx_valid=0 and busy=0 the next cycle, and no done pulse.
//      A new start then begins again at x0, byte 0.
//   5. Write x5 = 32'hDEAD_BEEF in the same cycle LOAD reads x5.
//      Expect bytes EF BE AD DE for x5, via forwarding.
//   6. With REGFILE_DUMP_CKSUM_EN and all registers = 32'h0101_0101 except x0 = 0:
//      expect 129 bytes, and the last byte equals 8'h00 (XOR of 124 bytes of 01).
//      Then set x1 = 32'h0000_0001 and expect a checksum of 8'h01.

Source files
------------

// File: rtl/regfile_dump_tx_pkg.sv
// Shared state encodings and constants for the register file dump transmitter.
// Optional checksum byte is controlled by the REGFILE_DUMP_CKSUM_EN macro.
package regfile_dump_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StSend  = 3'd2;
    localparam logic [2:0] StCksum = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned BYTES_PER_WORD = DATA_W_DEFAULT / 8;

    localparam logic [7:0] CKSUM_INIT = 8'h00;

    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Counter width that stays legal even for a single-byte word.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_dump_tx_word_byte_serializer.sv
// Word-to-byte shift register for the dump transmitter; emits the low byte first.
// Independent of REGFILE_DUMP_CKSUM_EN.
module word_byte_serializer
    import regfile_dump_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] word_in,
    input  logic              advance,
    output logic [7:0]        byte_out,
    output logic              last
);

    localparam int unsigned Bytes = bytes_per_word(DATA_W);
    localparam int unsigned CntW  = cnt_width(Bytes);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]   byte_idx_q, byte_idx_d;

    always_comb begin
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        if (load) begin
            shift_d    = word_in;
            byte_idx_d = '0;
        end else if (advance) begin
            shift_d    = shift_q >> 8;
            byte_idx_d = byte_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            byte_idx_q <= '0;
        end else begin
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    assign byte_out = shift_q[7:0];
    assign last     = (byte_idx_q == CntW'(Bytes - 1));

endmodule

// File: rtl/regfile_dump_tx.sv
// Streams x0..x(NUM_REGS-1) little-endian as bytes on a valid/ready link after a start pulse.
// Define REGFILE_DUMP_CKSUM_EN to append an XOR checksum byte to every frame.
module regfile_dump_tx
    import regfile_dump_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam logic [ADDR_W-1:0] LastReg = ADDR_W'(NUM_REGS - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] reg_idx_q, reg_idx_d;
    logic              ser_load, ser_advance, ser_last;
    logic [7:0]        ser_byte;
    logic              handshake;
`ifdef REGFILE_DUMP_CKSUM_EN
    logic [7:0]        cksum_q, cksum_d;
`endif

    word_byte_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk      (clk),
        .reset    (reset),
        .load     (ser_load),
        .word_in  (rd_data),
        .advance  (ser_advance),
        .byte_out (ser_byte),
        .last     (ser_last)
    );

    // Address tracks the index in every state so the read-port mux never sees a glitch.
    assign rd_addr   = reg_idx_q;
    assign handshake = tx_valid & tx_ready;

    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            StSend: begin
                tx_valid = 1'b1;
                tx_data  = ser_byte;
            end
`ifdef REGFILE_DUMP_CKSUM_EN
            StCksum: begin
                tx_valid = 1'b1;
                tx_data  = cksum_q;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        reg_idx_d   = reg_idx_q;
        ser_load    = 1'b0;
        ser_advance = 1'b0;
`ifdef REGFILE_DUMP_CKSUM_EN
        cksum_d     = cksum_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    reg_idx_d = '0;
`ifdef REGFILE_DUMP_CKSUM_EN
                    cksum_d   = CKSUM_INIT;
`endif
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                ser_load = 1'b1;
                state_d  = StSend;
            end
            StSend: begin
                if (handshake) begin
                    ser_advance = 1'b1;
`ifdef REGFILE_DUMP_CKSUM_EN
                    cksum_d     = cksum_q ^ ser_byte;
`endif
                    if (ser_last) begin
                        if (reg_idx_q == LastReg) begin
`ifdef REGFILE_DUMP_CKSUM_EN
                            state_d = StCksum;
`else
                            state_d = StDone;
`endif
                        end else begin
                            reg_idx_d = reg_idx_q + 1'b1;
                            state_d   = StLoad;
                        end
                    end
                end
            end
`ifdef REGFILE_DUMP_CKSUM_EN
            StCksum: begin
                if (handshake) begin
                    state_d = StDone;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            reg_idx_q <= '0;
`ifdef REGFILE_DUMP_CKSUM_EN
            cksum_q   <= CKSUM_INIT;
`endif
        end else begin
            state_q   <= state_d;
            reg_idx_q <= reg_idx_d;
`ifdef REGFILE_DUMP_CKSUM_EN
            cksum_q   <= cksum_d;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Directed bench for regfile_dump_tx with a behavioural register file including write forwarding.
// Checksum expectations apply when REGFILE_DUMP_CKSUM_EN is defined.
module tb_regfile_dump_tx;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
`ifdef REGFILE_DUMP_CKSUM_EN
    localparam int FRAME_BYTES = NUM_REGS * DATA_W / 8 + 1;
    localparam int DONE_CYCLE  = 162;
`else
    localparam int FRAME_BYTES = NUM_REGS * DATA_W / 8;
    localparam int DONE_CYCLE  = 161;
`endif

    logic              clk = 1'b0;
    logic              reset, start, busy, done, tx_valid, tx_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        tx_data;

    logic [31:0] regs [NUM_REGS];
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rd_data = (wr_en && wr_addr == rd_addr) ? wr_data : regs[rd_addr];

    regfile_dump_tx #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame from an IDLE cycle and leaves the bench in the cycle after DONE.
    task automatic run_frame(input string tag, input int stall_pct, input bit restart_mid,
                             input bit start_in_done, input bit fwd, output logic [7:0] last_byte);
        logic [7:0]  exp_q[$];
        logic [31:0] word;
        logic [7:0]  x, held;
        int          nacc, ndone, done_cyc, cyc;
        bit          stalled, restarted;
        exp_q = {};
        x = 8'h00;
        for (int r = 0; r < NUM_REGS; r++) begin
            word = (fwd && r == 5) ? 32'hDEAD_BEEF : regs[r];
            for (int b = 0; b < DATA_W / 8; b++) begin
                exp_q.push_back(word[8*b +: 8]);
                x ^= word[8*b +: 8];
            end
        end
`ifdef REGFILE_DUMP_CKSUM_EN
        exp_q.push_back(x);
`endif
        nacc = 0; ndone = 0; done_cyc = -1; stalled = 0; restarted = 0; held = 8'h00;
        last_byte = 8'hxx;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (ndone == 0 && cyc < 3000) begin
            tx_ready = ($urandom_range(99) >= stall_pct);
            wr_en    = 1'b0;
            start    = 1'b0;
            if (fwd && busy && !tx_valid && rd_addr == 5) begin
                wr_en   = 1'b1;
                wr_addr = 5'd5;
                wr_data = 32'hDEAD_BEEF;
            end
            if (restart_mid && !restarted && nacc == 40 && tx_valid) begin
                start     = 1'b1;
                restarted = 1;
            end
            if (stalled) begin
                chk({tag, "_stall_valid"}, {31'd0, tx_valid}, 32'd1);
                chk({tag, "_stall_data"}, {24'd0, tx_data}, {24'd0, held});
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
                if (start_in_done) start = 1'b1;
            end
            if (tx_valid && tx_ready) begin
                if (nacc < FRAME_BYTES) chk({tag, "_byte"}, {24'd0, tx_data}, {24'd0, exp_q[nacc]});
                else chk({tag, "_extra_byte"}, nacc, FRAME_BYTES - 1);
                last_byte = tx_data;
                nacc++;
            end
            stalled = tx_valid && !tx_ready;
            held    = tx_data;
            tick();
            cyc++;
            if (wr_en) regs[wr_addr] = wr_data;
        end
        start = 1'b0;
        wr_en = 1'b0;
        chk({tag, "_done_seen"}, ndone, 1);
        chk({tag, "_byte_count"}, nacc, FRAME_BYTES);
        if (stall_pct == 0) chk({tag, "_done_cycle"}, done_cyc, DONE_CYCLE);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [7:0] lb;
        int         n, cyc;
        bit         seen;
        reset = 1'b1; start = 1'b0; tx_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        regs[0] = 32'h0;
        for (int i = 1; i < NUM_REGS; i++) regs[i] = 32'h1000_0000 + i;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_rd_addr", {27'd0, rd_addr}, 32'd0);

        // 1: full-rate frame
        run_frame("t1", 0, 0, 0, 0, lb);
`ifndef REGFILE_DUMP_CKSUM_EN
        chk("t1_last_byte", {24'd0, lb}, 32'h10);
`endif

        // 2: 30% backpressure
        run_frame("t2", 30, 0, 0, 0, lb);

        // 3: starts mid-frame and in DONE ignored, then back-to-back frame
        run_frame("t3a", 0, 1, 1, 0, lb);
        run_frame("t3b", 0, 0, 0, 0, lb);

        // 4: reset while presenting byte 2 of x7
        tx_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; cyc = 0;
        while (!(tx_valid && n == 30) && cyc < 500) begin
            if (tx_valid) n++;
            tick();
            cyc++;
        end
        chk("t4_rd_addr_x7", {27'd0, rd_addr}, 32'd7);
        chk("t4_byte2_x7", {24'd0, tx_data}, 32'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_rd_addr", {27'd0, rd_addr}, 32'd0);
        seen = 0;
        repeat (20) begin
            if (done || tx_valid) seen = 1;
            tick();
        end
        chk("t4_quiet", {31'd0, seen}, 32'd0);
        run_frame("t4b", 0, 0, 0, 0, lb);

        // 5: same-cycle write to x5 must be forwarded into the capture
        regs[5] = 32'h1000_0005;
        run_frame("t5", 0, 0, 0, 1, lb);
        chk("t5_reg_written", regs[5], 32'hDEAD_BEEF);

        // 6: checksum patterns
        regs[0] = 32'h0;
        for (int i = 1; i < NUM_REGS; i++) regs[i] = 32'h0101_0101;
        run_frame("t6a", 0, 0, 0, 0, lb);
`ifdef REGFILE_DUMP_CKSUM_EN
        chk("t6a_cksum", {24'd0, lb}, 32'h00);
`else
        chk("t6a_last_byte", {24'd0, lb}, 32'h01);
`endif
        regs[1] = 32'h0000_0001;
        run_frame("t6b", 20, 0, 0, 0, lb);
`ifdef REGFILE_DUMP_CKSUM_EN
        chk("t6b_cksum", {24'd0, lb}, 32'h01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
